// File: rtl/inert_spi_resp_if.sv
// rtl/inert_spi_resp_if.sv - SPI link bundle between the pitch-sensor master and responder
interface inert_spi_resp_if;
  logic SS_n;
  logic SCLK;
  logic MOSI;
  logic MISO;
  logic INT;

  modport master (output SS_n, output SCLK, output MOSI, input MISO, input INT);
  modport slave  (input SS_n, input SCLK, input MOSI, output MISO, output INT);
endinterface

// File: rtl/inert_spi_resp.sv
// rtl/inert_spi_resp.sv - SPI inertial-sensor responder (INERT_RESP_AUTO_SMPL_EN: internal ramp sampler)
module inert_spi_resp #(
  parameter int SMPL_PERIOD = 20000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  inert_spi_resp_if.slave        spi,
  input  logic                   smpl_vld,
  input  logic [15:0]            smpl_ptch
);

  typedef enum logic [1:0] {
    ST_WAIT_HIGH,
    ST_IDLE,
    ST_FRAME
  } state_e;

  localparam logic [6:0] A_INT1_CTRL = 7'h0D;
  localparam logic [6:0] A_WHO_AM_I  = 7'h0F;
  localparam logic [6:0] A_CTRL1     = 7'h10;
  localparam logic [6:0] A_CTRL2     = 7'h11;
  localparam logic [6:0] A_STATUS    = 7'h1E;
  localparam logic [6:0] A_PTCH_L    = 7'h22;
  localparam logic [6:0] A_PTCH_H    = 7'h23;
  localparam logic [7:0] WHO_AM_I_V  = 8'h6A;

  state_e      state_q, state_d;
  logic [2:0]  ss_q, ss_d;
  logic [2:0]  sclk_q, sclk_d;
  logic [1:0]  mosi_q, mosi_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] shift_q, shift_d;
  logic        rd_en_q, rd_en_d;
  logic [7:0]  rd_byte_q, rd_byte_d;
  logic [7:0]  hold_cand_q, hold_cand_d;
  logic        miso_q, miso_d;
  logic        int_q, int_d;
  logic [7:0]  int1_ctrl_q, int1_ctrl_d;
  logic [7:0]  ctrl1_q, ctrl1_d;
  logic [7:0]  ctrl2_q, ctrl2_d;
  logic [15:0] ptch_q, ptch_d;
  logic [7:0]  hold_h_q, hold_h_d;
  logic        hold_vld_q, hold_vld_d;
  logic        drdy_q, drdy_d;
  logic        ovr_q, ovr_d;

  logic        ss_fall, ss_rise, sclk_rise, sclk_fall;
  logic [15:0] shift_nx;
  logic [7:0]  rd_mux;
  logic        frame_ok;
  logic        wr_commit, rd_commit, ptch_h_clr;
  logic        smpl_stb;
  logic [15:0] smpl_val;

  assign ss_fall   =  ss_q[2]   & ~ss_q[1];
  assign ss_rise   = ~ss_q[2]   &  ss_q[1];
  assign sclk_rise = ~sclk_q[2] &  sclk_q[1];
  assign sclk_fall =  sclk_q[2] & ~sclk_q[1];
  assign shift_nx  = {shift_q[14:0], mosi_q[1]};

  assign spi.MISO = miso_q;
  assign spi.INT  = int_q;

`ifdef INERT_RESP_AUTO_SMPL_EN
  localparam int CW = $clog2(SMPL_PERIOD) + 1;

  logic [CW-1:0] per_cnt_q, per_cnt_d;
  logic [15:0]   ramp_q, ramp_d;
  logic          unused_smpl_ports;

  assign unused_smpl_ports = smpl_vld ^ (^smpl_ptch);
  assign smpl_stb = (ctrl1_q != 8'h00) && (per_cnt_q == CW'(SMPL_PERIOD - 1));
  assign smpl_val = ramp_q;

  always_comb begin
    per_cnt_d = per_cnt_q + 1'b1;
    ramp_d    = ramp_q;
    if (ctrl1_q == 8'h00) begin
      per_cnt_d = '0;
    end else if (smpl_stb) begin
      per_cnt_d = '0;
      ramp_d    = ramp_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt_q <= '0;
      ramp_q    <= '0;
    end else begin
      per_cnt_q <= per_cnt_d;
      ramp_q    <= ramp_d;
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg = ^SMPL_PERIOD;
  assign smpl_stb   = smpl_vld;
  assign smpl_val   = smpl_ptch;
`endif

  // Address comes from the partially shifted command so the byte can be latched on the 8th rise.
  always_comb begin
    rd_mux = 8'h00;
    unique case (shift_nx[6:0])
      A_INT1_CTRL: rd_mux = int1_ctrl_q;
      A_WHO_AM_I:  rd_mux = WHO_AM_I_V;
      A_CTRL1:     rd_mux = ctrl1_q;
      A_CTRL2:     rd_mux = ctrl2_q;
      A_STATUS:    rd_mux = {6'b0, ovr_q, drdy_q};
      A_PTCH_L:    rd_mux = ptch_q[7:0];
      A_PTCH_H:    rd_mux = hold_vld_q ? hold_h_q : ptch_q[15:8];
      default:     rd_mux = 8'h00;
    endcase
  end

  always_comb begin
    ss_d        = {ss_q[1:0], spi.SS_n};
    sclk_d      = {sclk_q[1:0], spi.SCLK};
    mosi_d      = {mosi_q[0], spi.MOSI};
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rd_en_d     = rd_en_q;
    rd_byte_d   = rd_byte_q;
    hold_cand_d = hold_cand_q;
    miso_d      = miso_q;
    int1_ctrl_d = int1_ctrl_q;
    ctrl1_d     = ctrl1_q;
    ctrl2_d     = ctrl2_q;
    ptch_d      = ptch_q;
    hold_h_d    = hold_h_q;
    hold_vld_d  = hold_vld_q;
    drdy_d      = drdy_q;
    ovr_d       = ovr_q;
    frame_ok    = 1'b0;

    unique case (state_q)
      ST_WAIT_HIGH: begin
        if (ss_q[1]) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (ss_fall) begin
          state_d   = ST_FRAME;
          bit_cnt_d = '0;
          shift_d   = '0;
          rd_en_d   = 1'b0;
        end
      end
      ST_FRAME: begin
        if (ss_rise) begin
          state_d  = ST_IDLE;
          miso_d   = 1'b0;
          frame_ok = (bit_cnt_q == 5'd16);
        end else begin
          if (sclk_rise) begin
            shift_d = shift_nx;
            // Saturate so a very long burst can never wrap back to a valid count.
            if (bit_cnt_q != 5'd31) bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              rd_en_d     = shift_nx[7];
              rd_byte_d   = shift_nx[7] ? rd_mux : 8'h00;
              hold_cand_d = ptch_q[15:8];
            end
          end
          if (sclk_fall) begin
            miso_d = (rd_en_q && bit_cnt_q[4:3] == 2'b01) ? rd_byte_q[~bit_cnt_q[2:0]] : 1'b0;
          end
        end
      end
      default: state_d = ST_WAIT_HIGH;
    endcase

    wr_commit  = frame_ok & ~shift_q[15];
    rd_commit  = frame_ok &  shift_q[15];
    ptch_h_clr = rd_commit && (shift_q[14:8] == A_PTCH_H);

    if (wr_commit) begin
      unique case (shift_q[14:8])
        A_INT1_CTRL: int1_ctrl_d = shift_q[7:0];
        A_CTRL1:     ctrl1_d     = shift_q[7:0];
        A_CTRL2:     ctrl2_d     = shift_q[7:0];
        default:     ;
      endcase
    end
    if (rd_commit && (shift_q[14:8] == A_PTCH_L)) begin
      hold_h_d   = hold_cand_q;
      hold_vld_d = 1'b1;
    end
    if (ptch_h_clr) hold_vld_d = 1'b0;

    // A sample arriving with the PTCH_H clear keeps drdy set but starts a fresh overrun window.
    if (smpl_stb) begin
      ptch_d = smpl_val;
      drdy_d = 1'b1;
      ovr_d  = ptch_h_clr ? 1'b0 : (ovr_q | drdy_q);
    end else if (ptch_h_clr) begin
      drdy_d = 1'b0;
      ovr_d  = 1'b0;
    end

    int_d = drdy_q & int1_ctrl_q[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_WAIT_HIGH;
      ss_q        <= '0;
      sclk_q      <= '0;
      mosi_q      <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rd_en_q     <= 1'b0;
      rd_byte_q   <= '0;
      hold_cand_q <= '0;
      miso_q      <= 1'b0;
      int_q       <= 1'b0;
      int1_ctrl_q <= '0;
      ctrl1_q     <= '0;
      ctrl2_q     <= '0;
      ptch_q      <= '0;
      hold_h_q    <= '0;
      hold_vld_q  <= 1'b0;
      drdy_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ss_q        <= ss_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rd_en_q     <= rd_en_d;
      rd_byte_q   <= rd_byte_d;
      hold_cand_q <= hold_cand_d;
      miso_q      <= miso_d;
      int_q       <= int_d;
      int1_ctrl_q <= int1_ctrl_d;
      ctrl1_q     <= ctrl1_d;
      ctrl2_q     <= ctrl2_d;
      ptch_q      <= ptch_d;
      hold_h_q    <= hold_h_d;
      hold_vld_q  <= hold_vld_d;
      drdy_q      <= drdy_d;
      ovr_q       <= ovr_d;
    end
  end

endmodule

// File: tb/tb_inert_spi_resp.sv
// tb/tb_inert_spi_resp.sv - directed plus randomized bench for inert_spi_resp against a register-level model
`timescale 1ns/1ps
module tb_inert_spi_resp;
  logic        clk;
  logic        rst_n;
  logic        smpl_vld;
  logic [15:0] smpl_ptch;
  int          total;
  int          bad;
  int          last_lat;

  inert_spi_resp_if bus ();

  inert_spi_resp dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi       (bus.slave),
    .smpl_vld  (smpl_vld),
    .smpl_ptch (smpl_ptch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  // Register-level model of the sensor
  logic [7:0]  m_int1, m_ctrl1, m_ctrl2, m_hold;
  logic [15:0] m_ptch;
  logic        m_drdy, m_ovr, m_hflag;

  task automatic m_reset();
    m_int1 = 0; m_ctrl1 = 0; m_ctrl2 = 0; m_hold = 0;
    m_ptch = 0; m_drdy = 0; m_ovr = 0; m_hflag = 0;
  endtask

  function automatic logic [7:0] m_read(input logic [6:0] a);
    case (a)
      7'h0D:   return m_int1;
      7'h0F:   return 8'h6A;
      7'h10:   return m_ctrl1;
      7'h11:   return m_ctrl2;
      7'h1E:   return {6'b0, m_ovr, m_drdy};
      7'h22:   return m_ptch[7:0];
      7'h23:   return m_hflag ? m_hold : m_ptch[15:8];
      default: return 8'h00;
    endcase
  endfunction

  task automatic m_after_read(input logic [6:0] a);
    if (a == 7'h22) begin m_hold = m_ptch[15:8]; m_hflag = 1; end
    if (a == 7'h23) begin m_drdy = 0; m_ovr = 0; m_hflag = 0; end
  endtask

  task automatic m_write(input logic [6:0] a, input logic [7:0] d);
    if (a == 7'h0D) m_int1 = d;
    if (a == 7'h10) m_ctrl1 = d;
    if (a == 7'h11) m_ctrl2 = d;
  endtask

  task automatic m_sample(input logic [15:0] v);
    if (m_drdy) m_ovr = 1;
    m_drdy = 1;
    m_ptch = v;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic spi_bits(input logic [15:0] cmd, input int n, output logic [15:0] resp);
    resp = '0;
    for (int i = 0; i < n; i++) begin
      bus.MOSI = cmd[15-i];
      repeat (10) @(negedge clk);
      resp[15-i] = bus.MISO;
      bus.SCLK = 1'b1;
      repeat (10) @(negedge clk);
      bus.SCLK = 1'b0;
    end
  endtask

  task automatic spi_xfer(input logic [15:0] cmd, input int n, output logic [15:0] resp);
    @(negedge clk);
    bus.SS_n = 1'b0;
    repeat (6) @(negedge clk);
    spi_bits(cmd, n, resp);
    repeat (6) @(negedge clk);
    bus.SS_n = 1'b1;
    last_lat = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (last_lat < 0 && bus.INT === 1'b0) last_lat = k;
    end
    chk("miso_idle", 32'(bus.MISO), 32'd0);
  endtask

  task automatic do_read(input logic [6:0] a, input string tag);
    logic [15:0] r;
    logic [7:0]  e;
    e = m_read(a);
    spi_xfer({1'b1, a, 8'h00}, 16, r);
    m_after_read(a);
    chk(tag, 32'(r), {24'h0, e});
  endtask

  task automatic do_write(input logic [6:0] a, input logic [7:0] d);
    logic [15:0] r;
    spi_xfer({1'b0, a, d}, 16, r);
    m_write(a, d);
  endtask

  task automatic pulse_sample(input logic [15:0] v);
    @(negedge clk);
    smpl_vld = 1'b1; smpl_ptch = v;
    @(negedge clk);
    smpl_vld = 1'b0;
    m_sample(v);
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_int(input string tag);
    chk(tag, 32'(bus.INT), 32'(m_drdy & m_int1[1]));
  endtask

  logic [6:0]  addr_tab [9];
  logic [15:0] resp;
  logic [6:0]  a;

  initial begin
    total = 0; bad = 0; last_lat = 0;
    addr_tab = '{7'h0D, 7'h0F, 7'h10, 7'h11, 7'h1E, 7'h22, 7'h23, 7'h05, 7'h7F};
    rst_n = 1'b0; smpl_vld = 1'b0; smpl_ptch = '0;
    bus.SS_n = 1'b1; bus.SCLK = 1'b0; bus.MOSI = 1'b0;
    m_reset();
    repeat (4) @(negedge clk);
    chk("rst_miso", 32'(bus.MISO), 32'd0);
    chk("rst_int", 32'(bus.INT), 32'd0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    do_read(7'h1E, "rst_status");
    do_read(7'h0D, "rst_int1");
    do_read(7'h23, "rst_ptch_h");
    do_read(7'h0F, "who_am_i");

    do_write(7'h0F, 8'h00);
    do_read(7'h0F, "who_am_i_ro");
    do_write(7'h05, 8'hFF);
    do_read(7'h05, "unmapped");
    do_write(7'h11, 8'hA5);
    do_read(7'h11, "ctrl2_rw");

    do_write(7'h0D, 8'h02);
    chk_int("int_idle");
    @(negedge clk);
    smpl_vld = 1'b1; smpl_ptch = 16'h1234;
    @(negedge clk);
    smpl_vld = 1'b0;
    m_sample(16'h1234);
    chk("int_1clk", 32'(bus.INT), 32'd0);
    @(negedge clk);
    chk("int_2clk", 32'(bus.INT), 32'd1);
    do_read(7'h22, "ptch_l");
    do_read(7'h23, "ptch_h");
    chk("int_fall_lat", 32'(last_lat >= 1 && last_lat <= 5), 32'd1);
    do_read(7'h1E, "status_clr");

    pulse_sample(16'h1234);
    do_read(7'h22, "tear_l");
    pulse_sample(16'hABCD);
    do_read(7'h1E, "status_ovr");
    chk_int("int_before_h");
    do_read(7'h23, "tear_h");
    chk_int("int_after_h");
    do_read(7'h22, "new_l");
    do_read(7'h23, "new_h");

    spi_xfer({1'b0, 7'h10, 8'h55}, 12, resp);
    do_read(7'h10, "short_wr");
    pulse_sample(16'h0F0F);
    spi_xfer({1'b1, 7'h23, 8'h00}, 15, resp);
    chk_int("short_rd_int");
    do_read(7'h1E, "short_rd_status");

    for (int it = 0; it < 30; it++) begin
      a = addr_tab[$urandom_range(0, 8)];
      case ($urandom_range(0, 3))
        0: pulse_sample(16'($urandom));
        1: do_read(a, "rnd_read");
        2: do_write(a, 8'($urandom));
        default: begin
          do_read(7'h22, "rnd_pair_l");
          do_read(7'h23, "rnd_pair_h");
        end
      endcase
      chk_int("rnd_int");
    end

    do_write(7'h0D, 8'h02);
    pulse_sample(16'h5A5A);
    chk_int("pre_rst_int");
    @(negedge clk);
    bus.SS_n = 1'b0;
    repeat (6) @(negedge clk);
    spi_bits({1'b0, 7'h0D, 8'h02}, 10, resp);
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("midrst_miso", 32'(bus.MISO), 32'd0);
    chk("midrst_int", 32'(bus.INT), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    spi_bits({1'b0, 7'h0D, 8'h02}, 16, resp);
    repeat (6) @(negedge clk);
    bus.SS_n = 1'b1;
    repeat (12) @(negedge clk);
    do_read(7'h0D, "midrst_int1");
    do_read(7'h1E, "midrst_status");
    do_read(7'h22, "midrst_ptch");
    chk_int("midrst_int_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/inert_spi_resp.md
# inert_spi_resp

Synthesizable SPI responder that stands in for the inertial sensor on the far end of the pitch-measurement link (`SS_n`, `SCLK`, `MOSI`, `MISO`, `INT`). It decodes 16-bit command frames from the SPI master and answers register reads. It latches pitch samples into read-only registers and raises a data-ready interrupt. It is the counterpart of the inertial interface inside the digital core and is used for full-chip simulation and FPGA bring-up without a physical sensor.

## Interface
- `SMPL_PERIOD`, default 20000: clocks between internal samples; only used when `INERT_RESP_AUTO_SMPL_EN` is defined.
- `clk`  in  1  system clock. Single clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `SS_n`  in  1  slave select from the master, active-low; asynchronous to `clk`.
- `SCLK`  in  1  serial clock from the master; idles low; asynchronous to `clk`.
- `MOSI`  in  1  command/write data, MSB first.
- `MISO`  out  1  read data, MSB first.
- `INT`  out  1  data-ready interrupt, active-high, level.
- `smpl_vld`  in  1  one-clock strobe that loads a new pitch sample.
- `smpl_ptch`  in  16  signed pitch sample, captured when `smpl_vld` is high.

## Operation
- **Input synchronization:** `SS_n`, `SCLK` and `MOSI` each pass through a 2-flop synchronizer. A third flop on `SS_n` and `SCLK` provides edge detection. All protocol actions occur on synced edges.
- **Frame format:** 16 bits, SPI mode 0.
  - The master changes `MOSI` on the `SCLK` fall; the block samples on the synced `SCLK` rise.
  - Bit 15 = R/W (1 = read). Bits 14:8 = address. Bits 7:0 = write data (don't-care for reads).
- **Frame control:**
  - Synced `SS_n` fall clears the bit counter (5 bits) and the receive shifter.
  - Synced `SS_n` rise ends the frame.
  - A frame is valid only if exactly 16 rises were counted. Invalid frames cause no write and no side effect.
- **Read data:**
  - When the 8th rise is seen with bit 15 = 1, the addressed register byte is latched.
  - `MISO` = 0 for response bits 15:8.
  - Data bits 7..0 are presented MSB first. The first bit is driven on the 8th synced fall; each subsequent fall advances one bit.
  - `MISO` changes only on synced falls, and returns to 0 on synced `SS_n` rise.
- **Register map** (unmapped addresses read 0x00; writes to RO or unmapped addresses are ignored):
  - 0x0D INT1_CTRL, RW, reset 0x00. Bit 1 = data-ready interrupt enable.
  - 0x0F WHO_AM_I, RO, 0x6A.
  - 0x10 CTRL1, RW, reset 0x00.
  - 0x11 CTRL2, RW, reset 0x00.
  - 0x1E STATUS, RO. Bit 0 = data ready (`drdy`). Bit 1 = overrun (`ovr`).
  - 0x22 PTCH_L, RO. Reading it also copies the current high byte into `hold_h`.
  - 0x23 PTCH_H, RO. Returns `hold_h` if a PTCH_L read occurred since the last PTCH_H read; otherwise returns the live high byte.
- **Writes:** committed on synced `SS_n` rise of a valid frame with bit 15 = 0.
- **Sample load** (`smpl_vld` high):
  - `ptch` <= `smpl_ptch`.
  - If `drdy` is already set, `ovr` <= 1.
  - `drdy` <= 1.
- **Clearing:** a valid read of 0x23 clears `drdy` and `ovr` at frame end.
- **Interrupt:** `INT` = `drdy` & INT1_CTRL[1], registered (one flop after `drdy`).
- **Simultaneous sample load and PTCH_H clear in the same clock:** the sample wins. `drdy` stays 1 and `ovr` is cleared.
- **Startup with `SS_n` low:** if `SS_n` is low when reset is released, the block ignores all `SCLK` activity until a synced `SS_n` high is seen.
- **Reset during a frame:** the frame is aborted. No write is committed and no side effect occurs.

## Timing
- **Reset values:** `MISO`=0, `INT`=0, `drdy`=0, `ovr`=0, `ptch`=0x0000, `hold_h`=0x00, RW registers 0x00, bit counter 0.
- **Edge latency:** 3 clocks from an external `SCLK` or `SS_n` edge to its detect pulse.
- **Master requirements:** each `SCLK` phase ≥ 8 clocks; `SS_n` setup and hold around the `SCLK` burst ≥ 4 clocks.
- **`MISO` timing:** valid ≤ 4 clocks after the external `SCLK` fall.
- **`INT` timing:**
  - Rises 2 clocks after the `smpl_vld` cycle, provided interrupts are enabled.
  - Falls 2 clocks after synced `SS_n` rise of the PTCH_H read (≤ 5 clocks after the external `SS_n` rise).
- **Register write visibility:** a written value takes effect the clock after synced `SS_n` rise. Enabling INT1_CTRL[1] while `drdy` = 1 raises `INT` one clock later.

## Configuration
- **`INERT_RESP_AUTO_SMPL_EN` defined:**
  - `smpl_vld` and `smpl_ptch` are ignored.
  - An internal counter generates a sample strobe every `SMPL_PERIOD` clocks, but only while CTRL1 ≠ 0x00. The counter is held at 0 while CTRL1 = 0x00.
  - The sample value is a 16-bit ramp: it starts at 0x0000 and increments by 1 per sample, wrapping 0xFFFF→0x0000.
- **Not defined:** samples come only from the ports; no counter is present.

## Test plan
- **WHO_AM_I read:** read 0x0F (frame 0x8F00) -> `MISO` bits 7:0 = 0x6A, bits 15:8 = 0x00.
- **Interrupt enable and read-out:**
  - Write 0x0D=0x02, then `smpl_vld` with `smpl_ptch`=0x1234 -> `INT` high 2 clocks later.
  - Read 0x22 -> 0x34. Read 0x23 -> 0x12.
  - `INT` low within 5 clocks of `SS_n` rise; STATUS reads 0x00.
- **Tear protection and overrun:**
  - Load 0x1234, read PTCH_L (0x34), load 0xABCD, read PTCH_H -> 0x12 (held byte).
  - Read STATUS before the PTCH_H read -> 0x03; `INT` stays high until that read.
- **Short frame:** write 0x10=0x55 with only 12 `SCLK` pulses -> CTRL1 stays 0x00. Read 0x23 with 15 pulses -> `INT` stays high.
- **Reset mid-frame:** assert `rst_n` after 10 bits of write 0x0D=0x02 -> all outputs return to reset values; INT1_CTRL = 0x00. A later `SCLK` burst while `SS_n` is held low is ignored.
- **Auto-sample (`INERT_RESP_AUTO_SMPL_EN`, `SMPL_PERIOD`=100):**
  - Write 0x10=0x01 and 0x0D=0x02 -> `INT` every 100 clocks while unread.
  - Successive PTCH reads return 0x0000, 0x0001, ...
  - Write 0x10=0x00 -> sampling stops.
